// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// clock_pkg : shared widths, field ranges and EN bit positions for the
//             alarm-clock timekeeping datapath.
// Rev 1.0
// ============================================================================
package clock_pkg;

    localparam int HOUR_W    = 5;
    localparam int MIN_W     = 6;
    localparam int HOURS_MAX = 23;
    localparam int MINS_MAX  = 59;
    localparam int SECS_MAX  = 59;

    localparam int EN_TH  = 4;
    localparam int EN_TM  = 3;
    localparam int EN_AH  = 2;
    localparam int EN_AM  = 1;
    localparam int EN_RUN = 0;

endpackage : clock_pkg
`default_nettype wire

// File: rtl/clock_time_core_mod_counter.sv
`default_nettype none
// ============================================================================
// mod_counter : modulo-(MAX+1) up/down counter with sync clear and carry out.
// Rev 1.0
// ============================================================================
module mod_counter #(
    parameter int           W       = 6,
    parameter int           MAX     = 59,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         carry
);

    localparam logic [W-1:0] c_max = W'(MAX);

    logic w_step_up;
    logic w_step_dn;

    // Opposing requests cancel; clear dominates both.
    assign w_step_up = inc & ~dec & ~clr;
    assign w_step_dn = dec & ~inc & ~clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= '0;
        end else if (w_step_up) begin
            q <= (q == c_max) ? '0 : q + 1'b1;
        end else if (w_step_dn) begin
            q <= (q == '0) ? c_max : q - 1'b1;
        end
    end

    // Asserted on the edge where the count wraps MAX->0 or borrows 0->MAX.
    assign carry = (w_step_up & (q == c_max)) | (w_step_dn & (q == '0));

endmodule : mod_counter
`default_nettype wire

// File: rtl/clock_time_core.sv
`default_nettype none
// ============================================================================
// clock_time_core : 24 h time-of-day and alarm registers with 1 Hz prescaler,
//                   button adjust and alarm-match flag for the control FSM.
// Rev 1.0
// ============================================================================
module clock_time_core
    import clock_pkg::*;
#(
    parameter int               TICK_DIV    = 100_000_000,
    parameter logic [HOUR_W-1:0] ALARM_RST_H = 5'd7,
    parameter logic [MIN_W-1:0]  ALARM_RST_M = 6'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adjust,
    input  logic [4:0]        EN,
    input  logic              up,
    input  logic              down,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  mins,
    output logic [MIN_W-1:0]  secs,
    output logic [HOUR_W-1:0] al_hours,
    output logic [MIN_W-1:0]  al_mins,
    output logic              Z,
    output logic              tick_1hz
);

    localparam int                   c_presc_w    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);

    logic [c_presc_w-1:0] r_presc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (r_presc == c_presc_last) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign tick_1hz = (r_presc == c_presc_last);

    logic w_up;
    logic w_dn;
    logic w_time_sel;
    logic w_time_adj;
    logic w_run;
    logic w_secs_carry;
    logic w_mins_carry;
    logic w_hours_carry_unused;
    logic w_al_mins_carry_unused;
    logic w_al_hours_carry_unused;

    assign w_up       = adjust & up & ~down;
    assign w_dn       = adjust & down & ~up;
    assign w_time_sel = EN[EN_TH] | EN[EN_TM];
    assign w_time_adj = w_time_sel & (w_up | w_dn);
    // Any time-field select freezes the run path, even without a button.
    assign w_run      = tick_1hz & EN[EN_RUN] & ~w_time_sel;

    mod_counter #(.W(MIN_W), .MAX(SECS_MAX), .RST_VAL('0)) u_secs (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_run),
        .dec   (1'b0),
        .clr   (w_time_adj),
        .q     (secs),
        .carry (w_secs_carry)
    );

    mod_counter #(.W(MIN_W), .MAX(MINS_MAX), .RST_VAL('0)) u_mins (
        .clk   (clk),
        .rst   (rst),
        .inc   ((EN[EN_TM] & w_up) | w_secs_carry),
        .dec   (EN[EN_TM] & w_dn),
        .clr   (1'b0),
        .q     (mins),
        .carry (w_mins_carry)
    );

    // Minute wrap only ripples into hours while running, never while adjusting.
    mod_counter #(.W(HOUR_W), .MAX(HOURS_MAX), .RST_VAL('0)) u_hours (
        .clk   (clk),
        .rst   (rst),
        .inc   ((EN[EN_TH] & w_up) | (w_run & w_mins_carry)),
        .dec   (EN[EN_TH] & w_dn),
        .clr   (1'b0),
        .q     (hours),
        .carry (w_hours_carry_unused)
    );

    mod_counter #(.W(MIN_W), .MAX(MINS_MAX), .RST_VAL(ALARM_RST_M)) u_al_mins (
        .clk   (clk),
        .rst   (rst),
        .inc   (EN[EN_AM] & w_up),
        .dec   (EN[EN_AM] & w_dn),
        .clr   (1'b0),
        .q     (al_mins),
        .carry (w_al_mins_carry_unused)
    );

    mod_counter #(.W(HOUR_W), .MAX(HOURS_MAX), .RST_VAL(ALARM_RST_H)) u_al_hours (
        .clk   (clk),
        .rst   (rst),
        .inc   (EN[EN_AH] & w_up),
        .dec   (EN[EN_AH] & w_dn),
        .clr   (1'b0),
        .q     (al_hours),
        .carry (w_al_hours_carry_unused)
    );

    assign Z = (hours == al_hours) && (mins == al_mins);

endmodule : clock_time_core
`default_nettype wire

// File: tb/tb_clock_time_core.sv
`default_nettype none
// ============================================================================
// tb_clock_time_core : directed self-checking bench, TICK_DIV = 4.
// Rev 1.0
// ============================================================================
module tb_clock_time_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       adjust = 1'b0;
    logic [4:0] EN = 5'b0;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic [4:0] hours;
    logic [5:0] mins;
    logic [5:0] secs;
    logic [4:0] al_hours;
    logic [5:0] al_mins;
    logic       Z;
    logic       tick_1hz;

    int n_checks = 0;
    int n_fail   = 0;

    clock_time_core #(.TICK_DIV(4), .ALARM_RST_H(5'd7), .ALARM_RST_M(6'd0)) dut (
        .clk      (clk),
        .rst      (rst),
        .adjust   (adjust),
        .EN       (EN),
        .up       (up),
        .down     (down),
        .hours    (hours),
        .mins     (mins),
        .secs     (secs),
        .al_hours (al_hours),
        .al_mins  (al_mins),
        .Z        (Z),
        .tick_1hz (tick_1hz)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] tv(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic u, input logic d);
        up   = u;
        down = d;
        step();
        up   = 1'b0;
        down = 1'b0;
    endtask

    // Advance until the edge that consumes the next tick; bounded.
    task automatic wait_tick();
        int k = 0;
        while (tick_1hz !== 1'b1 && k < 8) begin
            step();
            k++;
        end
        if (k == 8) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: tick_1hz never rose within 8 clk");
        end
        step();
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_checks++;
        if ({hours, mins, secs} !== tv(0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_time: got %0d:%0d:%0d expected 0:0:0", hours, mins, secs);
        end
        n_checks++;
        if ({al_hours, al_mins} !== {5'd7, 6'd0}) begin
            n_fail++;
            $display("FAIL reset_alarm: got %0d:%0d expected 7:0", al_hours, al_mins);
        end
        n_checks++;
        if (Z !== 1'b0 || tick_1hz !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got Z=%b tick=%b expected Z=0 tick=0", Z, tick_1hz);
        end
        rst = 1'b0;
        // Prescaler leaves reset at 0, so ticks appear after the 3rd, 7th... edge.
        for (int i = 1; i <= 8; i++) begin
            step();
            n_checks++;
            if (tick_1hz !== ((i % 4) == 3)) begin
                n_fail++;
                $display("FAIL tick_period[%0d]: got %b expected %b", i, tick_1hz, ((i % 4) == 3));
            end
        end
    endtask

    task automatic test_run_carry();
        adjust = 1'b1;
        EN = 5'b10000;
        pulse(1'b0, 1'b1);
        EN = 5'b01000;
        pulse(1'b0, 1'b1);
        adjust = 1'b0;
        EN = 5'b00001;
        run_ticks(59);
        n_checks++;
        if ({hours, mins, secs} !== tv(23, 59, 59)) begin
            n_fail++;
            $display("FAIL run_pre_wrap: got %0d:%0d:%0d expected 23:59:59", hours, mins, secs);
        end
        run_ticks(1);
        n_checks++;
        if ({hours, mins, secs} !== tv(0, 0, 0)) begin
            n_fail++;
            $display("FAIL run_day_wrap: got %0d:%0d:%0d expected 0:0:0", hours, mins, secs);
        end
        run_ticks(60);
        n_checks++;
        if ({hours, mins, secs} !== tv(0, 1, 0)) begin
            n_fail++;
            $display("FAIL run_60_ticks: got %0d:%0d:%0d expected 0:1:0", hours, mins, secs);
        end
    endtask

    task automatic test_time_adjust();
        run_ticks(37);
        n_checks++;
        if ({hours, mins, secs} !== tv(0, 1, 37)) begin
            n_fail++;
            $display("FAIL adj_setup: got %0d:%0d:%0d expected 0:1:37", hours, mins, secs);
        end
        adjust = 1'b1;
        EN = 5'b10000;
        pulse(1'b0, 1'b1);
        n_checks++;
        if ({hours, mins, secs} !== tv(23, 1, 0)) begin
            n_fail++;
            $display("FAIL adj_hours_down: got %0d:%0d:%0d expected 23:1:0", hours, mins, secs);
        end
        pulse(1'b1, 1'b0);
        n_checks++;
        if ({hours, mins, secs} !== tv(0, 1, 0)) begin
            n_fail++;
            $display("FAIL adj_hours_up: got %0d:%0d:%0d expected 0:1:0", hours, mins, secs);
        end
        EN = 5'b10001;
        run_ticks(2);
        n_checks++;
        if ({hours, mins, secs} !== tv(0, 1, 0)) begin
            n_fail++;
            $display("FAIL adj_blocks_run: got %0d:%0d:%0d expected 0:1:0", hours, mins, secs);
        end
    endtask

    task automatic test_alarm_adjust();
        EN = 5'b00010;
        pulse(1'b0, 1'b1);
        n_checks++;
        if ({al_hours, al_mins} !== {5'd7, 6'd59}) begin
            n_fail++;
            $display("FAIL al_mins_down: got %0d:%0d expected 7:59", al_hours, al_mins);
        end
        // Land the button on the edge right after a tick so the two never overlap.
        wait_tick();
        EN = 5'b00011;
        pulse(1'b1, 1'b0);
        n_checks++;
        if ({al_hours, al_mins} !== {5'd7, 6'd0}) begin
            n_fail++;
            $display("FAIL al_mins_wrap: got %0d:%0d expected 7:0", al_hours, al_mins);
        end
        run_ticks(3);
        n_checks++;
        if ({hours, mins, secs} !== tv(0, 1, 3)) begin
            n_fail++;
            $display("FAIL al_adj_time_runs: got %0d:%0d:%0d expected 0:1:3", hours, mins, secs);
        end
    endtask

    task automatic test_alarm_match();
        EN = 5'b10000;
        for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0);
        EN = 5'b01000;
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        adjust = 1'b0;
        EN = 5'b00001;
        run_ticks(59);
        n_checks++;
        if ({hours, mins, secs, Z} !== {tv(6, 59, 59), 1'b0}) begin
            n_fail++;
            $display("FAIL z_before: got %0d:%0d:%0d Z=%b expected 6:59:59 Z=0", hours, mins, secs, Z);
        end
        run_ticks(1);
        n_checks++;
        if ({hours, mins, secs, Z} !== {tv(7, 0, 0), 1'b1}) begin
            n_fail++;
            $display("FAIL z_match: got %0d:%0d:%0d Z=%b expected 7:0:0 Z=1", hours, mins, secs, Z);
        end
        run_ticks(59);
        n_checks++;
        if (Z !== 1'b1) begin
            n_fail++;
            $display("FAIL z_level: got Z=%b expected Z=1 at 7:0:59", Z);
        end
        run_ticks(1);
        n_checks++;
        if ({hours, mins, secs, Z} !== {tv(7, 1, 0), 1'b0}) begin
            n_fail++;
            $display("FAIL z_after: got %0d:%0d:%0d Z=%b expected 7:1:0 Z=0", hours, mins, secs, Z);
        end
    endtask

    task automatic test_corner_cases();
        run_ticks(5);
        adjust = 1'b1;
        EN = 5'b10000;
        pulse(1'b1, 1'b1);
        n_checks++;
        if ({hours, mins, secs} !== tv(7, 1, 5)) begin
            n_fail++;
            $display("FAIL up_down_cancel: got %0d:%0d:%0d expected 7:1:5", hours, mins, secs);
        end
        adjust = 1'b0;
        pulse(1'b1, 1'b0);
        n_checks++;
        if ({hours, mins, secs} !== tv(7, 1, 5)) begin
            n_fail++;
            $display("FAIL adjust_low_ignored: got %0d:%0d:%0d expected 7:1:5", hours, mins, secs);
        end
        adjust = 1'b1;
        EN = 5'b00100;
        pulse(1'b1, 1'b0);
        n_checks++;
        if ({al_hours, al_mins} !== {5'd8, 6'd0}) begin
            n_fail++;
            $display("FAIL al_hours_up: got %0d:%0d expected 8:0", al_hours, al_mins);
        end
        adjust = 1'b0;
        EN = 5'b00001;
        run_ticks(2);
        step();
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({hours, mins, secs, al_hours, al_mins, tick_1hz} !== {tv(0, 0, 0), 5'd7, 6'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got %0d:%0d:%0d al %0d:%0d tick=%b expected 0:0:0 al 7:0 tick=0",
                     hours, mins, secs, al_hours, al_mins, tick_1hz);
        end
        step();
        rst = 1'b0;
        EN = 5'b00000;
    endtask

    initial begin
        test_reset();
        test_run_carry();
        test_time_adjust();
        test_alarm_adjust();
        test_alarm_match();
        test_corner_cases();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_clock_time_core
`default_nettype wire
